qdiv: RTL

QDIV -- requirements
Module: qdiv

---
 rtl/qdiv_if.sv | 24 ++
 rtl/qdiv.sv | 116 +++++++++++
 2 files changed

// File: rtl/qdiv_if.sv
// Operand/result bundle for qdiv: start, operands and the saturated quotient.
// No backpressure: start is simply ignored while busy is high.
interface qdiv_if #(
   parameter int N = 20
);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] q_result;
   logic         overflow;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, q_result, overflow, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, q_result, overflow, div_by_zero
   );
endinterface

// File: rtl/qdiv.sv
// Signed Q-format restoring divider with saturation; done N+Q+1 edges after the accepting edge.
// No backpressure: start is accepted only in IDLE and ignored while busy.
module qdiv #(
   parameter int Q = 11,
   parameter int N = 20
) (
   input  logic  clk,
   input  logic  rst,
   qdiv_if.slave bus
);
   localparam int W  = N + Q;
   localparam int CW = $clog2(W) + 1;

   localparam logic [W-1:0] POS_LIM = {{(Q+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic [W-1:0] NEG_LIM = {{Q{1'b0}}, 1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] MAX_Q   = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_Q   = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [N-1:0]  dvs_mag;
   logic [W-1:0]  num;
   logic [W-1:0]  quo;
   logic [N-1:0]  rem;
   logic          sign;
   logic          dz;
   logic [CW-1:0] cnt;

   logic          accept;
   logic          step;
   logic          wb;
   logic [N:0]    trial;
   logic          ge;
   logic [N-1:0]  rem_nxt;
   logic [N-1:0]  res_q;
   logic          res_ovf;

   assign accept = (state == IDLE) && bus.start;
   // cnt walks N+Q-1..0 producing one bit each; once negative, the next edge writes back
   assign step   = (state == CALC) && !cnt[CW-1];
   assign wb     = (state == CALC) &&  cnt[CW-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (cnt[CW-1]) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      trial   = {rem, num[W-1]};
      ge      = trial >= {1'b0, dvs_mag};
      rem_nxt = ge ? (trial[N-1:0] - dvs_mag) : trial[N-1:0];
   end

   // Negative magnitude of exactly 2^(N-1) negates to MIN_Q, so it needs no saturation
   always_comb begin
      res_ovf = 1'b0;
      res_q   = sign ? -quo[N-1:0] : quo[N-1:0];
      if (dz) begin
         res_q = sign ? MIN_Q : MAX_Q;
      end else if (!sign && (quo > POS_LIM)) begin
         res_q   = MAX_Q;
         res_ovf = 1'b1;
      end else if (sign && (quo > NEG_LIM)) begin
         res_q   = MIN_Q;
         res_ovf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvs_mag         <= '0;
         num             <= '0;
         quo             <= '0;
         rem             <= '0;
         sign            <= 1'b0;
         dz              <= 1'b0;
         cnt             <= '0;
         bus.q_result    <= '0;
         bus.overflow    <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         if (accept) begin
            dvs_mag <= bus.divisor[N-1] ? -bus.divisor : bus.divisor;
            num     <= {(bus.dividend[N-1] ? -bus.dividend : bus.dividend), {Q{1'b0}}};
            quo     <= '0;
            rem     <= '0;
            sign    <= bus.dividend[N-1] ^ bus.divisor[N-1];
            dz      <= (bus.divisor == '0);
            cnt     <= CW'(W - 1);
         end else if (step) begin
            num <= {num[W-2:0], 1'b0};
            rem <= rem_nxt;
            quo <= {quo[W-2:0], ge};
            cnt <= cnt - CW'(1);
         end
         if (wb) begin
            bus.q_result    <= res_q;
            bus.overflow    <= res_ovf;
            bus.div_by_zero <= dz;
         end
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
endmodule
